// File: rtl/dpram_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpram_fifo_ctrl_pkg
// Purpose  : Shared sizing helpers for the dual-port-RAM FIFO controller.
// Revision : 1.0 - initial release
// ============================================================================
package dpram_fifo_ctrl_pkg;

  // Number of RAM words addressed by a widthad-bit address.
  function automatic int fifo_depth(input int widthad);
    return 2 ** widthad;
  endfunction

  // Occupancy counters must reach DEPTH (RAM) or DEPTH+1 (RAM + output
  // stage), so they need one bit more than the address.
  function automatic int level_width(input int widthad);
    return widthad + 1;
  endfunction

endpackage : dpram_fifo_ctrl_pkg
`default_nettype wire

// File: rtl/dpram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dpram_fifo_ctrl_if
// Purpose  : Stream-side bundle of the FIFO controller: write stream (s_*),
//            read stream (m_*) and the occupancy level.
//            slave  = controller view, master = user view.
// Revision : 1.0 - initial release
// ============================================================================
interface dpram_fifo_ctrl_if
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int width   = 8,
  parameter int widthad = 4
);

  logic [width-1:0]                   s_data;
  logic                               s_valid;
  logic                               s_ready;
  logic [width-1:0]                   m_data;
  logic                               m_valid;
  logic                               m_ready;
  logic [level_width(widthad)-1:0]    level;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, level
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, level
  );

endinterface : dpram_fifo_ctrl_if
`default_nettype wire

// File: rtl/dpram_fifo_ctrl_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : dpram_fifo_ctrl_fifo_ptr
// Purpose  : widthad-bit RAM address pointer; advances on inc and wraps
//            naturally from DEPTH-1 to 0.
// Revision : 1.0 - initial release
// ============================================================================
module dpram_fifo_ctrl_fifo_ptr #(
  parameter int widthad = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [widthad-1:0] ptr
);

  logic [widthad-1:0] r_ptr;

  // Power-of-two depth: plain binary overflow gives the wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule : dpram_fifo_ctrl_fifo_ptr
`default_nettype wire

// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dpram_fifo_ctrl
// Purpose  : Show-ahead FIFO controller for an external simple dual-port RAM
//            with a 1-cycle registered read port. The RAM q register is the
//            output stage, so the controller holds no data flops.
// Options  : DPRAM_FIFO_CTRL_AFULL_EN - adds registered almost_full output
//            (level >= afull_thresh).
// Revision : 1.0 - initial release
// ============================================================================
module dpram_fifo_ctrl
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int width        = 8,
  parameter int widthad      = 4,
  parameter int afull_thresh = 2 ** widthad - 2
) (
  input  logic               clk,
  input  logic               rst,
  dpram_fifo_ctrl_if.slave   bus,
  output logic [widthad-1:0] ram_wraddress,
  output logic               ram_wren,
  output logic [width-1:0]   ram_data,
  output logic [widthad-1:0] ram_rdaddress,
  output logic               ram_rden,
  input  logic [width-1:0]   ram_q
`ifdef DPRAM_FIFO_CTRL_AFULL_EN
  ,
  output logic               almost_full
`endif
);

  localparam int              c_depth   = fifo_depth(widthad);
  localparam int              c_lw      = level_width(widthad);
  localparam logic [c_lw-1:0] c_depth_v = c_lw'(c_depth);

  logic               r_s_ready;
  logic               r_m_valid;
  logic [c_lw-1:0]    r_ram_cnt;
  logic [c_lw-1:0]    r_level;

  logic               w_wr;
  logic               w_rden;
  logic               w_m_valid_next;
  logic [c_lw-1:0]    w_ram_cnt_next;
  logic [c_lw-1:0]    w_level_next;
  logic [widthad-1:0] w_wr_ptr;
  logic [widthad-1:0] w_rd_ptr;

  // A write is a stream handshake; s_ready is registered, so a full FIFO
  // refuses for the whole cycle even if a pop frees a slot in it.
  assign w_wr = bus.s_valid && r_s_ready;

  // Only words already counted in r_ram_cnt are read, so a read can never
  // hit the address being written in the same cycle. The read fires when the
  // output register is empty or is being drained.
  assign w_rden = (r_ram_cnt != '0) && (!r_m_valid || bus.m_ready);

  // Output stage refills on a read, empties on a pop with no refill.
  assign w_m_valid_next = w_rden ? 1'b1 : (bus.m_ready ? 1'b0 : r_m_valid);

  // RAM word count: writes add, reads remove, both together cancel.
  always_comb begin
    w_ram_cnt_next = r_ram_cnt;
    case ({w_wr, w_rden})
      2'b10:   w_ram_cnt_next = r_ram_cnt + 1'b1;
      2'b01:   w_ram_cnt_next = r_ram_cnt - 1'b1;
      default: w_ram_cnt_next = r_ram_cnt;
    endcase
  end

  assign w_level_next = w_ram_cnt_next + {{(c_lw-1){1'b0}}, w_m_valid_next};

  // Control state; everything clears immediately on reset and the RAM
  // contents become unreachable stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_cnt <= '0;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b0;
      r_level   <= '0;
    end else begin
      r_ram_cnt <= w_ram_cnt_next;
      r_m_valid <= w_m_valid_next;
      r_s_ready <= (w_ram_cnt_next != c_depth_v);
      r_level   <= w_level_next;
    end
  end

  dpram_fifo_ctrl_fifo_ptr #(.widthad(widthad)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_wr),
    .ptr (w_wr_ptr)
  );

  dpram_fifo_ctrl_fifo_ptr #(.widthad(widthad)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_rden),
    .ptr (w_rd_ptr)
  );

  assign ram_wren      = w_wr;
  assign ram_wraddress = w_wr_ptr;
  assign ram_data      = bus.s_data;
  assign ram_rden      = w_rden;
  assign ram_rdaddress = w_rd_ptr;

  assign bus.s_ready   = r_s_ready;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_data    = ram_q;
  assign bus.level     = r_level;

`ifdef DPRAM_FIFO_CTRL_AFULL_EN
  localparam logic [c_lw-1:0] c_afull_v = c_lw'(afull_thresh);

  logic r_almost_full;

  // Flag tracks the registered level, so it is computed from the next level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_level_next >= c_afull_v);
    end
  end

  assign almost_full = r_almost_full;
`else
  // Threshold has no consumer without the almost-full flag.
  logic [31:0] w_unused_afull_thresh;
  assign w_unused_afull_thresh = afull_thresh;
`endif

endmodule : dpram_fifo_ctrl
`default_nettype wire
